// File: rtl/mag_comp_seq_if.sv
// Request/result bundle for the multi-cycle magnitude comparator.
// The master side issues start with operands; the slave side reports status and flags.
interface mag_comp_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             Equal;
  logic             A_greater;
  logic             B_greater;

  modport master (
    output start, A, B, signed_mode,
    input  busy, done, Equal, A_greater, B_greater
  );

  modport slave (
    input  start, A, B, signed_mode,
    output busy, done, Equal, A_greater, B_greater
  );
endinterface

// File: rtl/mag_comp_seq.sv
// Multi-cycle magnitude comparator: walks the captured operands CHUNK bits per
// clock from the most significant chunk down, latching the first difference.
// Signed compares flip both sign bits at capture so one unsigned walk serves both modes.
module mag_comp_seq #(
  parameter int WIDTH      = 16,
  parameter int CHUNK      = 4,
  parameter int EARLY_EXIT = 1
) (
  input logic          clk,
  input logic          rst,
  mag_comp_seq_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  IDX_TOP   = IDXW'(NCHUNK - 1);
  localparam logic [IDXW-1:0]  IDX_ZERO  = {IDXW{1'b0}};
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Select chunk i of an operand with a mux over the fixed chunk slices.
  function automatic logic [CHUNK-1:0] get_chunk(input logic [WIDTH-1:0] v,
                                                 input logic [IDXW-1:0]  i);
    logic [CHUNK-1:0] r;
    r = {CHUNK{1'b0}};
    for (int k = 0; k < NCHUNK; k++) begin
      if (i == IDXW'(k)) begin
        r = v[k*CHUNK +: CHUNK];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  state_t           state_r;
  logic [IDXW-1:0]  idx_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             decided_r;
  logic             gt_r;
  logic             busy_r;
  logic             done_r;
  logic             equal_r;
  logic             a_gt_r;
  logic             b_gt_r;

  logic [CHUNK-1:0] chunk_a_s;
  logic [CHUNK-1:0] chunk_b_s;
  logic             chunk_ne_s;
  logic             chunk_gt_s;
  logic             decided_s;
  logic             gt_s;
  logic             finish_s;

  // Evaluate the current chunk and merge it with any earlier decision.
  always_comb begin
    chunk_a_s  = get_chunk(a_r, idx_r);
    chunk_b_s  = get_chunk(b_r, idx_r);
    chunk_ne_s = (chunk_a_s != chunk_b_s);
    chunk_gt_s = (chunk_a_s > chunk_b_s);
    decided_s  = decided_r | chunk_ne_s;
    if (decided_r) begin
      gt_s = gt_r;
    end else begin
      gt_s = chunk_gt_s;
    end
    if (idx_r == IDX_ZERO) begin
      finish_s = 1'b1;
    end else if ((EARLY_EXIT != 0) && chunk_ne_s) begin
      finish_s = 1'b1;
    end else begin
      finish_s = 1'b0;
    end
  end

  // Control FSM with registered status and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      idx_r     <= IDX_ZERO;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      decided_r <= 1'b0;
      gt_r      <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      equal_r   <= 1'b0;
      a_gt_r    <= 1'b0;
      b_gt_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            // Flipping the sign bits maps two's-complement order onto unsigned order.
            if (bus.signed_mode) begin
              a_r <= bus.A ^ SIGN_MASK;
              b_r <= bus.B ^ SIGN_MASK;
            end else begin
              a_r <= bus.A;
              b_r <= bus.B;
            end
            idx_r     <= IDX_TOP;
            decided_r <= 1'b0;
            gt_r      <= 1'b0;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            state_r   <= ST_COMPARE;
          end else begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_COMPARE: begin
          if (finish_s) begin
            equal_r <= ~decided_s;
            a_gt_r  <= decided_s & gt_s;
            b_gt_r  <= decided_s & ~gt_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            idx_r     <= idx_r - IDXW'(1);
            decided_r <= decided_s;
            gt_r      <= gt_s;
            state_r   <= ST_COMPARE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.Equal     = equal_r;
  assign bus.A_greater = a_gt_r;
  assign bus.B_greater = b_gt_r;
endmodule
